// File: rtl/mips_multicycle_control.sv
// Multi-cycle control sequencer for the MIPS datapath: FETCH/DECODE/EXEC/MEM/WB
// with registered strobes, a retired-instruction counter and a sticky HALT.
module mips_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       op_control,
  input  logic [5:0]       funct_control,
  input  logic             zero,
  output logic             store,
  output logic             w_reg,
  output logic             w_data,
  output logic [5:0]       op_alu,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_ADD  = 6'b100000;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_ADDI = 6'd1;
  localparam logic [5:0] ALU_SUB  = 6'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [5:0]       r_op;
  logic [5:0]       r_funct;
  logic             r_store;
  logic             r_w_reg;
  logic             r_w_data;
  logic [5:0]       r_op_alu;
  logic             r_halted;
  logic [CNT_W-1:0] r_count;
  logic             w_unused;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_R:                             is_legal = (funct == FN_ADD);
      OP_J, OP_ADDI, OP_BEQ, OP_LW, OP_SW: is_legal = 1'b1;
      default:                          is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] alu_sel(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_LW, OP_SW: alu_sel = ALU_ADDI;
      OP_BEQ:                alu_sel = ALU_SUB;
      default:               alu_sel = ALU_ADD;
    endcase
  endfunction

  // Outputs are registered for the state being entered, so each strobe is
  // valid for the whole cycle of that state and drops with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_op     <= 6'd0;
      r_funct  <= 6'd0;
      r_store  <= 1'b0;
      r_w_reg  <= 1'b0;
      r_w_data <= 1'b0;
      r_op_alu <= ALU_ADD;
      r_halted <= 1'b0;
      r_count  <= '0;
    end else begin
      if (r_store) r_count <= r_count + CNT_ONE;
      r_store  <= 1'b0;
      r_w_reg  <= 1'b0;
      r_w_data <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (en) begin
            r_state <= S_DECODE;
            r_store <= (op_control == OP_J);
          end
        end
        S_DECODE: begin
          r_op    <= op_control;
          r_funct <= funct_control;
          if (!is_legal(op_control, funct_control)) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (op_control == OP_J) begin
            r_state <= S_FETCH;
          end else begin
            r_state  <= S_EXEC;
            r_op_alu <= alu_sel(op_control);
            r_store  <= (op_control == OP_BEQ);
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_BEQ: begin
              r_state  <= S_FETCH;
              r_op_alu <= ALU_ADD;
            end
            OP_LW, OP_SW: begin
              r_state  <= S_MEM;
              r_op_alu <= ALU_ADDI;
              r_w_data <= (r_op == OP_SW);
              r_store  <= (r_op == OP_SW);
            end
            default: begin
              r_state <= S_WB;
              r_w_reg <= 1'b1;
              r_store <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (r_op == OP_SW) begin
            r_state  <= S_FETCH;
            r_op_alu <= ALU_ADD;
          end else begin
            r_state <= S_WB;
            r_w_reg <= 1'b1;
            r_store <= 1'b1;
          end
        end
        S_WB: begin
          r_state  <= S_FETCH;
          r_op_alu <= ALU_ADD;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state  <= S_FETCH;
          r_op_alu <= ALU_ADD;
        end
      endcase
    end
  end

  // zero is informational; the funct latch is kept for datapath visibility only.
  assign w_unused = ^{zero, r_funct};

  assign store       = r_store;
  assign w_reg       = r_w_reg;
  assign w_data      = r_w_data;
  assign op_alu      = r_op_alu;
  assign state       = r_state;
  assign halted      = r_halted;
  assign instr_count = r_count;

endmodule
